// File: rtl/ltc_align_pkg.sv
// Shared definitions for the LTC2xxx frame-lane bitslip alignment logic.
package ltc_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED,
    ST_FAIL
  } ltc_state_t;

  localparam logic [3:0] FR_PATTERN_DEFAULT = 4'b1100;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ltc_frame_cmp.sv
// Frame-word comparator with saturating consecutive match / mismatch counters.
module ltc_frame_cmp #(
  parameter int               SER_W     = 4,
  parameter logic [SER_W-1:0] PATTERN   = '0,
  parameter int               MATCH_CNT = 64,
  parameter int               ERR_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [SER_W-1:0] frame,
  output logic             match,
  output logic             match_done,
  output logic             miss_done
);

  localparam int MW = $clog2(MATCH_CNT + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_CNT - 1);
  localparam logic [MW-1:0] MATCH_MAX  = MW'(MATCH_CNT);
  localparam logic [EW-1:0] MISS_LAST  = EW'(ERR_LIMIT - 1);
  localparam logic [EW-1:0] MISS_MAX   = EW'(ERR_LIMIT);

  logic [MW-1:0] match_cnt;
  logic [EW-1:0] miss_cnt;

  assign match = (frame == PATTERN);

  // Flags fire on the word that makes the count reach its limit.
  assign match_done = en && match && (match_cnt == MATCH_LAST);
  assign miss_done  = en && !match && (miss_cnt == MISS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else if (clr) begin
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else if (en) begin
      if (match) begin
        match_cnt <= (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + 1'b1;
        miss_cnt  <= '0;
      end else begin
        miss_cnt  <= (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + 1'b1;
        match_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ltc_frame_align.sv
// Bitslip-based word alignment of ISERDES2 lanes against the ADC frame lane.
module ltc_frame_align
  import ltc_align_pkg::*;
#(
  parameter int               NLANES     = 8,
  parameter int               SER_W      = 4,
  parameter logic [SER_W-1:0] FR_PATTERN = SER_W'(FR_PATTERN_DEFAULT),
  parameter int               SETTLE_CYC = 16,
  parameter int               MATCH_CNT  = 64,
  parameter int               MAX_SLIP   = 2 * SER_W,
  parameter int               ERR_LIMIT  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [SER_W-1:0]        frame_in,
  input  logic [NLANES*SER_W-1:0] data_in,
  output logic                    bitslip,
  output logic [NLANES*SER_W-1:0] data_out,
  output logic                    data_valid,
  output logic                    locked,
  output logic                    fail,
  output logic [7:0]              slip_count,
  output logic [7:0]              err_count
);

  localparam int AW = $clog2(MAX_SLIP + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [AW-1:0] MAX_ATT     = AW'(MAX_SLIP);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  ltc_state_t    state, next_state;
  logic [AW-1:0] attempts;
  logic [SW-1:0] settle_cnt;
  logic          cmp_clr, cmp_en;
  logic          frame_match, match_done, miss_done;

  ltc_frame_cmp #(
    .SER_W     (SER_W),
    .PATTERN   (FR_PATTERN),
    .MATCH_CNT (MATCH_CNT),
    .ERR_LIMIT (ERR_LIMIT)
  ) u_cmp (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (cmp_clr),
    .en         (cmp_en),
    .frame      (frame_in),
    .match      (frame_match),
    .match_done (match_done),
    .miss_done  (miss_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   next_state = ST_CHECK;
      ST_CHECK: begin
        if (match_done)       next_state = ST_LOCKED;
        else if (!frame_match) next_state = ST_SLIP;
      end
      ST_SLIP:   next_state = (attempts == MAX_ATT) ? ST_FAIL : ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) next_state = ST_CHECK;
      ST_LOCKED: if (miss_done) next_state = ST_CHECK;
      ST_FAIL:   next_state = ST_FAIL;
      default:   next_state = ST_IDLE;
    endcase
    if (start) next_state = ST_CHECK;

    // Comparator counts only in CHECK/LOCKED and restarts from zero on every state change.
    cmp_en  = (state == ST_CHECK) || (state == ST_LOCKED);
    cmp_clr = start || !cmp_en || (next_state != state);
  end

  assign bitslip = (state == ST_SLIP) && (attempts != MAX_ATT);
  assign locked  = (state == ST_LOCKED);
  assign fail    = (state == ST_FAIL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      attempts   <= '0;
      settle_cnt <= '0;
      slip_count <= '0;
      err_count  <= '0;
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      settle_cnt <= (state == ST_SETTLE && next_state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
      if (start) begin
        attempts   <= '0;
        slip_count <= '0;
        err_count  <= '0;
      end else begin
        if (bitslip) begin
          attempts   <= attempts + 1'b1;
          slip_count <= sat_inc8(slip_count);
        end
        if (state == ST_LOCKED && !frame_match) err_count <= sat_inc8(err_count);
      end
      data_valid <= locked;
      data_out   <= locked ? data_in : '0;
    end
  end

endmodule
